// File: rtl/instruction_memory_ctrl.sv
// Instruction memory with a program-load write port and a one-cycle-latency fetch port.
// Optional macro IMEM_RUNTIME_WRITE_EN: also honour load_en after loading (RUN), write-first.

module instruction_memory_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int INIT_MODE  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_done,
    output logic                  mem_ready,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_req_ready,
    output logic                  fetch_valid,
    input  logic                  fetch_ready,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_err
);

    // state  | meaning
    // S_LOAD | loader owns the array, fetch port closed
    // S_RUN  | fetch port open, left only by reset
    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int unsigned NWORDS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state_q, state_d;
    logic                  mem_ready_q, mem_ready_d;
    logic                  fetch_valid_q, fetch_valid_d;
    logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
    logic                  fetch_err_q, fetch_err_d;

    logic                  load_in_range;
    logic                  fetch_in_range;
    logic                  wr_en;
    logic                  accept;
    logic [DATA_WIDTH-1:0] rd_words [NWORDS];

    assign load_in_range  = ({1'b0, load_addr} < DEPTH_L);
    assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_L);

`ifdef IMEM_RUNTIME_WRITE_EN
    assign wr_en = load_en & load_in_range;
`else
    assign wr_en = load_en & load_in_range & (state_q == S_LOAD);
`endif

    assign fetch_req_ready = mem_ready_q & (~fetch_valid_q | fetch_ready);
    assign accept          = fetch_req & fetch_req_ready;

    // Unimplemented slots above DEPTH read as zero, so an out-of-range fetch yields 0.
    for (genvar i = 0; i < NWORDS; i++) begin : g_word
        if (i < DEPTH) begin : g_real
            logic [DATA_WIDTH-1:0] word_q = (INIT_MODE == 1) ? DATA_WIDTH'(i) : '0;
            logic [DATA_WIDTH-1:0] word_d;

            always_comb begin
                word_d = word_q;
                if (wr_en && (load_addr == ADDR_WIDTH'(i))) begin
                    word_d = load_data;
                end
            end

            always_ff @(posedge clock) begin
                word_q <= word_d;
            end

            assign rd_words[i] = word_q;
        end else begin : g_empty
            assign rd_words[i] = '0;
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_valid_d = fetch_valid_q;
        fetch_data_d  = fetch_data_q;
        fetch_err_d   = fetch_err_q;

        if ((state_q == S_LOAD) && load_done) begin
            state_d = S_RUN;
        end
        mem_ready_d = (state_d == S_RUN);

        if (accept) begin
            fetch_valid_d = 1'b1;
            fetch_data_d  = rd_words[fetch_addr];
            fetch_err_d   = ~fetch_in_range;
`ifdef IMEM_RUNTIME_WRITE_EN
            if (wr_en && (load_addr == fetch_addr)) begin
                fetch_data_d = load_data;
            end
`endif
        end else if (fetch_valid_q && fetch_ready) begin
            fetch_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_LOAD;
            mem_ready_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_ready_q   <= mem_ready_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    assign mem_ready   = mem_ready_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_data  = fetch_data_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instruction_memory_ctrl.sv
// Directed bench for instruction_memory_ctrl with DEPTH = 200 so out-of-range paths exist.

module tb_instruction_memory_ctrl;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          load_done;
    logic          mem_ready;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_req_ready;
    logic          fetch_valid;
    logic          fetch_ready;
    logic [DW-1:0] fetch_data;
    logic          fetch_err;

    int tests = 0;
    int fails = 0;

    instruction_memory_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (200),
        .INIT_MODE (0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .load_done      (load_done),
        .mem_ready      (mem_ready),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_req_ready(fetch_req_ready),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_data     (fetch_data),
        .fetch_err      (fetch_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch_one(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data,
                             input logic exp_err, input string tag);
        fetch_req   = 1'b1;
        fetch_addr  = addr;
        fetch_ready = 1'b1;
        cyc();
        check({tag, "_valid"}, 64'(fetch_valid), 64'd1);
        check({tag, "_data"}, 64'(fetch_data), 64'(exp_data));
        check({tag, "_err"}, 64'(fetch_err), 64'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
        fetch_req = 1'b0; fetch_addr = '0; fetch_ready = 1'b0;
        cyc();
        cyc();
        check("rst_mem_ready", 64'(mem_ready), 64'd0);
        check("rst_valid", 64'(fetch_valid), 64'd0);
        check("rst_data", 64'(fetch_data), 64'd0);
        check("rst_err", 64'(fetch_err), 64'd0);
        reset = 1'b0;

        // LOAD: fetch requests are ignored
        fetch_req = 1'b1; fetch_addr = 8'd5; fetch_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("load_req_ready", 64'(fetch_req_ready), 64'd0);
            cyc();
            check("load_valid", 64'(fetch_valid), 64'd0);
            check("load_mem_ready", 64'(mem_ready), 64'd0);
        end
        fetch_req = 1'b0;

        load_en = 1'b1; load_addr = 8'd3; load_data = 32'hDEADBEEF;
        cyc();
        load_addr = 8'd4; load_data = 32'h12345678;
        cyc();
        load_addr = 8'd220; load_data = 32'hA5A5A5A5;
        cyc();
        load_addr = 8'd10; load_data = 32'h10101010; load_done = 1'b1;
        #1;
        check("pre_done_mem_ready", 64'(mem_ready), 64'd0);
        cyc();
        check("post_done_mem_ready", 64'(mem_ready), 64'd1);
        check("post_done_valid", 64'(fetch_valid), 64'd0);
        load_en = 1'b0; load_done = 1'b0;

        // Back-to-back 3, 4, 3
        fetch_req = 1'b1; fetch_addr = 8'd3; fetch_ready = 1'b1;
        #1;
        check("run_req_ready", 64'(fetch_req_ready), 64'd1);
        cyc();
        check("b2b0_valid", 64'(fetch_valid), 64'd1);
        check("b2b0_data", 64'(fetch_data), 64'hDEADBEEF);
        check("b2b0_err", 64'(fetch_err), 64'd0);
        fetch_addr = 8'd4;
        cyc();
        check("b2b1_valid", 64'(fetch_valid), 64'd1);
        check("b2b1_data", 64'(fetch_data), 64'h12345678);
        fetch_addr = 8'd3;
        cyc();
        check("b2b2_valid", 64'(fetch_valid), 64'd1);
        check("b2b2_data", 64'(fetch_data), 64'hDEADBEEF);

        // Backpressure
        fetch_addr = 8'd4;
        cyc();
        check("bp_accept_data", 64'(fetch_data), 64'h12345678);
        fetch_ready = 1'b0; fetch_addr = 8'd3;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_req_ready", 64'(fetch_req_ready), 64'd0);
            cyc();
            check("bp_valid", 64'(fetch_valid), 64'd1);
            check("bp_data", 64'(fetch_data), 64'h12345678);
        end
        fetch_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(fetch_req_ready), 64'd1);
        cyc();
        check("bp_release_data", 64'(fetch_data), 64'hDEADBEEF);

        // Consume with no new request
        fetch_req = 1'b0;
        cyc();
        check("drain_valid", 64'(fetch_valid), 64'd0);
        check("drain_data_kept", 64'(fetch_data), 64'hDEADBEEF);

        // Range boundaries and the dropped addr-220 write
        fetch_one(8'd250, 32'h0, 1'b1, "oor250");
        fetch_one(8'd0, 32'h0, 1'b0, "addr0");
        fetch_one(8'd20, 32'h0, 1'b0, "addr20");
        fetch_one(8'd92, 32'h0, 1'b0, "addr92");
        fetch_one(8'd199, 32'h0, 1'b0, "addr199");
        fetch_one(8'd200, 32'h0, 1'b1, "oor200");
        fetch_one(8'd220, 32'h0, 1'b1, "oor220");
        fetch_one(8'd10, 32'h10101010, 1'b0, "addr10");

        // Reset while an output is stalled
        fetch_one(8'd3, 32'hDEADBEEF, 1'b0, "pre_rst");
        fetch_req = 1'b0; fetch_ready = 1'b0;
        cyc();
        check("stall_valid", 64'(fetch_valid), 64'd1);
        reset = 1'b1;
        cyc();
        check("midrst_valid", 64'(fetch_valid), 64'd0);
        check("midrst_mem_ready", 64'(mem_ready), 64'd0);
        check("midrst_data", 64'(fetch_data), 64'd0);
        reset = 1'b0; fetch_req = 1'b1; fetch_addr = 8'd3; fetch_ready = 1'b1;
        #1;
        check("midrst_req_ready", 64'(fetch_req_ready), 64'd0);
        fetch_req = 1'b0; load_done = 1'b1;
        cyc();
        load_done = 1'b0;
        check("reload_mem_ready", 64'(mem_ready), 64'd1);
        fetch_one(8'd3, 32'hDEADBEEF, 1'b0, "after_rst");

        // Write in RUN together with a fetch of the same address
        load_en = 1'b1; load_addr = 8'd3; load_data = 32'hCAFEF00D;
        fetch_req = 1'b1; fetch_addr = 8'd3; fetch_ready = 1'b1;
        cyc();
        load_en = 1'b0;
`ifdef IMEM_RUNTIME_WRITE_EN
        check("rt_wfirst_data", 64'(fetch_data), 64'hCAFEF00D);
        fetch_one(8'd3, 32'hCAFEF00D, 1'b0, "rt_readback");
        fetch_ready = 1'b0; fetch_req = 1'b0;
        load_en = 1'b1; load_addr = 8'd3; load_data = 32'h0BADF00D;
        cyc();
        load_en = 1'b0;
        check("rt_held_data", 64'(fetch_data), 64'hCAFEF00D);
        fetch_one(8'd3, 32'h0BADF00D, 1'b0, "rt_readback2");
`else
        check("run_write_ignored", 64'(fetch_data), 64'hDEADBEEF);
        fetch_one(8'd3, 32'hDEADBEEF, 1'b0, "run_readback");
`endif
        fetch_req = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
